// File: rtl/mdio_pkg.sv
// Shared definitions for the MDIO responder: FSM states, frame codes,
// register indices and register reset/base values.
package mdio_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ST,
    S_OP,
    S_PHYAD,
    S_REGAD,
    S_TA,
    S_WDATA,
    S_RDATA
  } mdio_state_e;

  localparam logic [1:0] ST_CODE  = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;

  localparam logic [4:0] REG_BMCR = 5'd0;
  localparam logic [4:0] REG_BMSR = 5'd1;
  localparam logic [4:0] REG_ID1  = 5'd2;
  localparam logic [4:0] REG_ID2  = 5'd3;

  localparam logic [15:0] BMCR_DEFAULT = 16'h3100;
  localparam logic [15:0] BMSR_BASE    = 16'h6009;

  localparam logic [5:0] PREAMBLE_LEN = 6'd32;

endpackage

// File: rtl/mdio_sampler.sv
// Brings MDC/MDIO into the clk_50M domain and flags rising MDC edges
// together with the MDIO value seen at that edge.
module mdio_sampler (
  input  logic clk_50M,
  input  logic rst,
  input  logic mdc,
  input  logic mdio_in,
  output logic mdc_rise,
  output logic mdio_s
);

  logic [1:0] mdc_sync;
  logic [1:0] mdio_sync;
  logic       mdc_prev;

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      mdc_sync  <= '0;
      mdio_sync <= 2'b11;
      mdc_prev  <= 1'b0;
    end else begin
      mdc_sync  <= {mdc_sync[0], mdc};
      mdio_sync <= {mdio_sync[0], mdio_in};
      mdc_prev  <= mdc_sync[1];
    end
  end

  assign mdc_rise = mdc_sync[1] & ~mdc_prev;
  assign mdio_s   = mdio_sync[1];

endmodule

// File: rtl/mdio_responder.sv
// Clause-22 MDIO PHY-side responder with BMCR/BMSR/ID/scratch registers.
// Define MDIO_RESP_BCAST_EN to also accept writes addressed to PHYAD 0.
module mdio_responder
  import mdio_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR = 5'd1,
  parameter logic [15:0] PHY_ID1  = 16'h0022,
  parameter logic [15:0] PHY_ID2  = 16'h1556
) (
  input  logic clk_50M,
  input  logic rst,
  input  logic mdc,
  input  logic mdio_in,
  output logic mdio_out,
  output logic mdio_z,
  input  logic link_up,
  output logic loopback_en,
  output logic trx_100Mbps_en,
  output logic fulldpx_en,
  output logic power_down,
  output logic frame_done
);

  logic        mdc_rise, mdio_s;
  mdio_state_e state, state_n;
  logic [4:0]  bit_cnt, bit_cnt_n;
  logic [5:0]  pre_cnt, pre_cnt_n;
  logic        op_hi, op_hi_n;
  logic        is_read, is_read_n;
  logic        ours, ours_n;
  logic [4:0]  phyad, phyad_n;
  logic [4:0]  regad, regad_n;
  logic [15:0] shift, shift_n;
  logic        mdio_out_n, mdio_z_n, frame_done_n;
  logic        wr_commit, rd_done, addr_match;
  logic [15:0] wr_data, rd_data;
  logic [15:0] bmcr;
  logic [15:0] scratch [16];
  logic        latched_link;

  mdio_sampler u_sampler (
    .clk_50M (clk_50M),
    .rst     (rst),
    .mdc     (mdc),
    .mdio_in (mdio_in),
    .mdc_rise(mdc_rise),
    .mdio_s  (mdio_s)
  );

`ifdef MDIO_RESP_BCAST_EN
  assign addr_match = (phyad == PHY_ADDR) || (!is_read && phyad == 5'd0);
`else
  assign addr_match = (phyad == PHY_ADDR);
`endif

  assign wr_data = {shift[14:0], mdio_s};

  always_comb begin
    rd_data = '0;
    if (regad[4]) begin
      rd_data = scratch[regad[3:0]];
    end else begin
      case (regad)
        REG_BMCR: rd_data = bmcr;
        REG_BMSR: rd_data = BMSR_BASE | {10'd0, link_up, 2'd0, latched_link, 2'd0};
        REG_ID1:  rd_data = PHY_ID1;
        REG_ID2:  rd_data = PHY_ID2;
        default:  rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      pre_cnt    <= '0;
      op_hi      <= 1'b0;
      is_read    <= 1'b0;
      ours       <= 1'b0;
      phyad      <= '0;
      regad      <= '0;
      shift      <= '0;
      mdio_out   <= 1'b1;
      mdio_z     <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      pre_cnt    <= pre_cnt_n;
      op_hi      <= op_hi_n;
      is_read    <= is_read_n;
      ours       <= ours_n;
      phyad      <= phyad_n;
      regad      <= regad_n;
      shift      <= shift_n;
      mdio_out   <= mdio_out_n;
      mdio_z     <= mdio_z_n;
      frame_done <= frame_done_n;
    end
  end

  // Everything advances only on an MDC rising edge; a read drives the bit
  // that the station will sample on its next rising edge.
  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    pre_cnt_n    = pre_cnt;
    op_hi_n      = op_hi;
    is_read_n    = is_read;
    ours_n       = ours;
    phyad_n      = phyad;
    regad_n      = regad;
    shift_n      = shift;
    mdio_out_n   = mdio_out;
    mdio_z_n     = mdio_z;
    frame_done_n = 1'b0;
    wr_commit    = 1'b0;
    rd_done      = 1'b0;
    if (mdc_rise) begin
      case (state)
        S_IDLE: begin
          if (mdio_s) begin
            if (pre_cnt != PREAMBLE_LEN) pre_cnt_n = pre_cnt + 6'd1;
          end else begin
            if (pre_cnt == PREAMBLE_LEN && mdio_s == ST_CODE[1]) state_n = S_ST;
            pre_cnt_n = '0;
          end
        end
        S_ST: begin
          bit_cnt_n = '0;
          state_n   = (mdio_s == ST_CODE[0]) ? S_OP : S_IDLE;
        end
        S_OP: begin
          if (bit_cnt == 5'd0) begin
            op_hi_n   = mdio_s;
            bit_cnt_n = 5'd1;
          end else begin
            bit_cnt_n = '0;
            if ({op_hi, mdio_s} == OP_READ) begin
              is_read_n = 1'b1;
              state_n   = S_PHYAD;
            end else if ({op_hi, mdio_s} == OP_WRITE) begin
              is_read_n = 1'b0;
              state_n   = S_PHYAD;
            end else begin
              state_n = S_IDLE;
            end
          end
        end
        S_PHYAD: begin
          phyad_n   = {phyad[3:0], mdio_s};
          bit_cnt_n = bit_cnt + 5'd1;
          if (bit_cnt == 5'd4) begin
            bit_cnt_n = '0;
            state_n   = S_REGAD;
          end
        end
        S_REGAD: begin
          regad_n   = {regad[3:0], mdio_s};
          bit_cnt_n = bit_cnt + 5'd1;
          if (bit_cnt == 5'd4) begin
            bit_cnt_n = '0;
            ours_n    = addr_match;
            state_n   = S_TA;
          end
        end
        S_TA: begin
          if (bit_cnt == 5'd0) begin
            bit_cnt_n = 5'd1;
            if (ours && is_read) begin
              mdio_z_n   = 1'b0;
              mdio_out_n = 1'b0;
              shift_n    = rd_data;
            end
          end else begin
            bit_cnt_n = '0;
            state_n   = is_read ? S_RDATA : S_WDATA;
            if (ours && is_read) begin
              mdio_out_n = shift[15];
              shift_n    = {shift[14:0], 1'b0};
            end
          end
        end
        S_RDATA: begin
          bit_cnt_n = bit_cnt + 5'd1;
          if (bit_cnt == 5'd15) begin
            state_n    = S_IDLE;
            mdio_z_n   = 1'b1;
            mdio_out_n = 1'b1;
            frame_done_n = ours;
            rd_done      = ours;
          end else if (ours) begin
            mdio_out_n = shift[15];
            shift_n    = {shift[14:0], 1'b0};
          end
        end
        S_WDATA: begin
          shift_n   = wr_data;
          bit_cnt_n = bit_cnt + 5'd1;
          if (bit_cnt == 5'd15) begin
            state_n      = S_IDLE;
            frame_done_n = ours;
            wr_commit    = ours;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      bmcr <= BMCR_DEFAULT;
      for (int i = 0; i < 16; i++) scratch[i] <= '0;
    end else if (wr_commit) begin
      if (regad == REG_BMCR) bmcr <= wr_data[15] ? BMCR_DEFAULT : wr_data;
      else if (regad[4]) scratch[regad[3:0]] <= wr_data;
    end
  end

  // Latch-low link status: a low link always clears, even against a read.
  always_ff @(posedge clk_50M) begin
    if (rst || !link_up) latched_link <= 1'b0;
    else if (rd_done && regad == REG_BMSR) latched_link <= 1'b1;
  end

  assign loopback_en    = bmcr[14];
  assign trx_100Mbps_en = bmcr[13];
  assign fulldpx_en     = bmcr[8];
  assign power_down     = bmcr[11];

endmodule

// File: tb/tb_mdio_responder.sv
// Scoreboard bench for mdio_responder: a station model issues clause-22 frames,
// a monitor captures driven bits and checks them when frame_done pulses.
module tb_mdio_responder;

  localparam logic [4:0] MY_ADDR = 5'd1;

  logic clk_50M = 1'b0;
  logic rst     = 1'b1;
  logic mdc     = 1'b0;
  logic st_drv  = 1'b1;
  logic link_up = 1'b1;
  logic mdio_in, mdio_out, mdio_z, frame_done;
  logic loopback_en, trx_100Mbps_en, fulldpx_en, power_down;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          is_read;
    logic [15:0] data;
  } exp_t;
  exp_t exp_q[$];

  logic [15:0] m_bmcr;
  logic [15:0] m_scratch [16];
  logic        m_latched;

  logic [16:0] cap = '0;
  int          cap_n = 0;
  int          z_low_total = 0;
  int          done_total = 0;
  logic        mdc_q = 1'b0;
  exp_t        mon_e;

  always #10 clk_50M = ~clk_50M;

  assign mdio_in = mdio_z ? st_drv : mdio_out;

  mdio_responder dut (
    .clk_50M       (clk_50M),
    .rst           (rst),
    .mdc           (mdc),
    .mdio_in       (mdio_in),
    .mdio_out      (mdio_out),
    .mdio_z        (mdio_z),
    .link_up       (link_up),
    .loopback_en   (loopback_en),
    .trx_100Mbps_en(trx_100Mbps_en),
    .fulldpx_en    (fulldpx_en),
    .power_down    (power_down),
    .frame_done    (frame_done)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_50M);
    #2;
  endtask

  task automatic mdc_bit(input logic b);
    st_drv = b;
    tick(8);
    mdc = 1'b1;
    tick(8);
    mdc = 1'b0;
  endtask

  function automatic logic accepts_write(input logic [4:0] phy);
`ifdef MDIO_RESP_BCAST_EN
    return (phy == MY_ADDR) || (phy == 5'd0);
`else
    return phy == MY_ADDR;
`endif
  endfunction

  task automatic model_reset();
    m_bmcr = 16'h3100;
    for (int i = 0; i < 16; i++) m_scratch[i] = '0;
    m_latched = 1'b0;
  endtask

  function automatic logic [15:0] model_read(input logic [4:0] r);
    if (r == 5'd0) return m_bmcr;
    if (r == 5'd1) return 16'h6009 | (16'(link_up) << 5) | (16'(m_latched) << 2);
    if (r == 5'd2) return 16'h0022;
    if (r == 5'd3) return 16'h1556;
    if (r >= 5'd16) return m_scratch[r - 5'd16];
    return 16'h0000;
  endfunction

  task automatic model_write(input logic [4:0] r, input logic [15:0] d);
    if (r == 5'd0) m_bmcr = d[15] ? 16'h3100 : d;
    else if (r >= 5'd16) m_scratch[r - 5'd16] = d;
  endtask

  task automatic set_link(input logic v);
    link_up = v;
    if (!v) m_latched = 1'b0;
    tick(4);
  endtask

  task automatic check_exports();
    checkOutput("loopback_en", loopback_en, m_bmcr[14]);
    checkOutput("trx_100Mbps_en", trx_100Mbps_en, m_bmcr[13]);
    checkOutput("fulldpx_en", fulldpx_en, m_bmcr[8]);
    checkOutput("power_down", power_down, m_bmcr[11]);
  endtask

  // One station frame; abort_at >= 0 pulses rst just before that bit index.
  task automatic applyStimulus(input int pre, input bit is_read, input logic [4:0] phy,
                               input logic [4:0] r, input logic [15:0] d, input int abort_at);
    bit   q[$];
    bit   ours;
    exp_t e;
    for (int i = 0; i < pre; i++) q.push_back(1'b1);
    q.push_back(1'b0);
    q.push_back(1'b1);
    q.push_back(is_read);
    q.push_back(!is_read);
    for (int i = 4; i >= 0; i--) q.push_back(phy[i]);
    for (int i = 4; i >= 0; i--) q.push_back(r[i]);
    q.push_back(1'b1);
    q.push_back(is_read ? 1'b1 : 1'b0);
    for (int i = 15; i >= 0; i--) q.push_back(is_read ? 1'b1 : d[i]);

    ours = (pre >= 32) && (abort_at < 0) && (is_read ? (phy == MY_ADDR) : accepts_write(phy));
    if (ours) begin
      e.is_read = is_read;
      if (is_read) begin
        e.data = model_read(r);
        if (r == 5'd1) m_latched = link_up;
      end else begin
        e.data = d;
        model_write(r, d);
      end
      exp_q.push_back(e);
    end

    for (int i = 0; i < q.size(); i++) begin
      if (i == abort_at) begin
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        st_drv = 1'b1;
        model_reset();
        tick(2);
        return;
      end
      mdc_bit(q[i]);
    end
    st_drv = 1'b1;
    tick(12);
    if (ours) checkOutput("frame_done_seen", exp_q.size(), 0);
  endtask

  // Monitor: captures responder-driven bits at station MDC rises and scores
  // them against the oldest expectation whenever frame_done pulses.
  always @(negedge clk_50M) begin
    if (!mdio_z) z_low_total++;
    if (mdc && !mdc_q && !mdio_z) begin
      cap = {cap[15:0], mdio_out};
      cap_n++;
    end
    mdc_q = mdc;
    if (frame_done) begin
      done_total++;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_frame_done", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.is_read) begin
          checkOutput("rd_driven_bits", cap_n, 17);
          checkOutput("rd_ta_and_data", {15'd0, cap}, {15'd0, 1'b0, mon_e.data});
        end else begin
          checkOutput("wr_driven_bits", cap_n, 0);
        end
        checkOutput("released_at_done", mdio_z, 1);
      end
      cap = '0;
      cap_n = 0;
    end
  end

  initial begin
    #1900000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int z0, d0;
    model_reset();
    tick(5);
    rst = 1'b0;
    tick(2);
    checkOutput("reset_mdio_z", mdio_z, 1);
    checkOutput("reset_mdio_out", mdio_out, 1);
    checkOutput("reset_frame_done", frame_done, 0);
    check_exports();

    applyStimulus(32, 1, MY_ADDR, 5'd2, '0, -1);
    applyStimulus(32, 1, MY_ADDR, 5'd3, '0, -1);

    applyStimulus(32, 0, MY_ADDR, 5'd0, 16'h4000, -1);
    check_exports();
    applyStimulus(32, 1, MY_ADDR, 5'd0, '0, -1);

    set_link(1'b0);
    set_link(1'b1);
    applyStimulus(32, 1, MY_ADDR, 5'd1, '0, -1);
    applyStimulus(32, 1, MY_ADDR, 5'd1, '0, -1);

    z0 = z_low_total;
    d0 = done_total;
    applyStimulus(32, 0, 5'd5, 5'd16, 16'hA5A5, -1);
    checkOutput("foreign_wr_released", z_low_total - z0, 0);
    checkOutput("foreign_wr_no_done", done_total - d0, 0);
    applyStimulus(32, 1, MY_ADDR, 5'd16, '0, -1);

    d0 = done_total;
    applyStimulus(31, 0, MY_ADDR, 5'd17, 16'hBEEF, -1);
    checkOutput("short_preamble_no_done", done_total - d0, 0);
    applyStimulus(32, 1, MY_ADDR, 5'd17, '0, -1);
    applyStimulus(32, 0, MY_ADDR, 5'd0, 16'h8000, -1);
    check_exports();
    applyStimulus(32, 1, MY_ADDR, 5'd0, '0, -1);

    applyStimulus(32, 0, MY_ADDR, 5'd5, 16'h1111, -1);
    applyStimulus(32, 1, MY_ADDR, 5'd5, '0, -1);

    z0 = z_low_total;
    applyStimulus(32, 1, 5'd0, 5'd2, '0, -1);
    checkOutput("bcast_read_released", z_low_total - z0, 0);
    applyStimulus(32, 0, 5'd0, 5'd17, 16'h1234, -1);
    applyStimulus(32, 1, MY_ADDR, 5'd17, '0, -1);

    for (int k = 0; k < 18; k++) begin
      logic [4:0] phy, r;
      bit rd;
      int sel;
      sel = $urandom_range(0, 9);
      phy = (sel < 7) ? MY_ADDR : ((sel == 7) ? 5'd0 : 5'd9);
      if ($urandom_range(0, 1) == 1) r = 5'(16 + $urandom_range(0, 15));
      else r = 5'($urandom_range(0, 7));
      rd = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 4) == 0) set_link(!link_up);
      applyStimulus(32 + $urandom_range(0, 3), rd, phy, r, 16'($urandom), -1);
      check_exports();
    end

    set_link(1'b1);
    applyStimulus(32, 0, MY_ADDR, 5'd17, 16'h5A5A, -1);
    applyStimulus(32, 0, MY_ADDR, 5'd0, 16'h0800, -1);
    applyStimulus(32, 0, MY_ADDR, 5'd17, 16'hFFFF, 32 + 16 + 8);
    checkOutput("abort_mdio_z", mdio_z, 1);
    checkOutput("abort_mdio_out", mdio_out, 1);
    check_exports();
    applyStimulus(32, 1, MY_ADDR, 5'd17, '0, -1);
    applyStimulus(32, 1, MY_ADDR, 5'd0, '0, -1);

    tick(20);
    checkOutput("pending_expectations", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdio_responder.md
# mdio_responder

PHY-side MDIO management responder: the far end of the MDC/MDIO station-management link that the Ethernet controller drives as initiator. It oversamples MDC/MDIO on the system clock, decodes IEEE 802.3 clause-22 frames, serves reads from a small PHY register file and commits writes. Its control bits (loopback, speed, duplex, power-down) are exported so the RMII datapath and LEDs reflect what the station programmed. It is used as an on-chip PHY model for loopback bring-up and for controller verification.

## Interface
- PHY_ADDR, 5'd1, address this responder answers to
- PHY_ID1, 16'h0022, value of register 2
- PHY_ID2, 16'h1556, value of register 3
- clk_50M  in  1  system clock; MDC/MDIO are sampled on it
- rst  in  1  synchronous, active-high reset
- mdc  in  1  management clock from station, asynchronous to clk_50M
- mdio_in  in  1  MDIO line as seen by the responder
- mdio_out  out  1  value driven onto MDIO when enabled; reset 1
- mdio_z  out  1  1 = responder releases MDIO (high-Z), 0 = drives mdio_out; reset 1
- link_up  in  1  current link status from the RMII side
- loopback_en  out  1  reg0[14]; reset 0
- trx_100Mbps_en  out  1  reg0[13]; reset 1
- fulldpx_en  out  1  reg0[8]; reset 1
- power_down  out  1  reg0[11]; reset 0
- frame_done  out  1  one-cycle pulse when a frame addressed to us completes; reset 0

## Operation
- mdc and mdio_in pass through 2-flop synchronisers. Rising MDC edge = sync'd mdc 0→1. mdio sampled value = synchronised mdio at that edge.
- Frame: ≥32 ones preamble, ST=01, OP (10 read, 01 write), PHYAD[4:0], REGAD[4:0], TA, DATA[15:0], all MSB first.
- States: IDLE, ST, OP, PHYAD, REGAD, TA, WDATA, RDATA. A 5-bit bit counter tracks field position.
- IDLE: counts consecutive 1s (saturating at 32). A 0 with count = 32 → ST (first ST bit consumed). A 0 with count < 32 clears count.
- ST second bit ≠ 1, or OP ∈ {00, 11} → IDLE, count cleared.
- After REGAD, the frame is "ours" iff PHYAD = PHY_ADDR. A frame that is not ours stays fully released but keeps tracking bits to the end of DATA, then → IDLE.
- Read (ours): during TA bit 1 the line stays released. After the edge sampling TA bit 1, drive 0 (mdio_z=0). After each subsequent edge, drive the next DATA bit, D15 first. After the edge on which D0 is sampled, release → IDLE and pulse frame_done.
- Write (ours): the TA bits are ignored. After the edge sampling D0, commit the register and pulse frame_done → IDLE.
- Register map:
  - 0 BMCR: read/write, reset 16'h3100. Bit 15 written 1 restores 16'h3100 and reads back 0.
  - 1 BMSR: read-only = 16'h6009 | link_up<<5 | latched_link<<2.
  - 2/3: PHY_ID1/PHY_ID2.
  - 16–31: 16-bit read/write scratch, reset 0.
  - All others read 0; writes to them are ignored.
- latched_link: cleared whenever link_up=0. Set to link_up at the end of a completed read of reg 1 (latch-low semantics).
- rst in mid-frame: → IDLE, count 0, mdio_z=1, mdio_out=1, registers to reset values. No partial write is committed.

## Timing
- The synchroniser plus edge detect give 3 clk_50M cycles of latency from the pin MDC edge to internal sampling. Drive changes are visible at most 4 cycles after the pin edge.
- MDC high and low phases must each be ≥ 6 clk_50M cycles. Faster MDC is unsupported.
- Write commit and frame_done occur 1 cycle after the internal D0 sampling edge.
- Exported BMCR bits update the cycle after commit.
- Simultaneous link_up falling and a reg-1 read completing: the clear wins.

## Configuration
- MDIO_RESP_BCAST_EN defined: PHYAD=0 is also accepted, for writes only. Reads to address 0 stay released.
- Undefined: only PHY_ADDR is accepted.

## Structure
- Shared package mdio_pkg holds:
  - the state enum;
  - ST/OP constants;
  - register indices (BMCR=0, BMSR=1, ID1=2, ID2=3);
  - the BMCR default 16'h3100 and the BMSR base value 16'h6009.
- Sub-module mdio_sampler holds the synchronisers and rising-edge detect, and outputs mdc_rise and mdio_s. The FSM and register file stay in mdio_responder.

## Test plan
- Reset, then read reg 2 at PHYAD 1 → TA2 driven 0, data 16'h0022, line released after D0, frame_done pulses once.
- Write reg 0 = 16'h4000 → loopback_en=1, trx_100Mbps_en=0, fulldpx_en=0. Read back → 16'h4000.
- link_up 1→0→1, read reg 1 → 16'h6029 (bit2=0). Second read → 16'h602D.
- Write reg 16 at PHYAD 5 → mdio_z stays 1 throughout, no frame_done. Read reg 16 at PHYAD 1 → 0.
- 31-bit preamble then a frame → ignored. 32-bit preamble → accepted. Write reg 0 bit 15 → reg 0 reads 16'h3100.
- rst asserted during WDATA bit 8 of a reg-17 write → mdio released, reg 17 reads 0 afterwards. With MDIO_RESP_BCAST_EN defined, a write at PHYAD 0 updates reg 17.
